tree_arb_requester: RTL and testbench

- Requester-side companion to the one-level tree arbiter in the router switch-allocation path; one instance per input port.
- Tracks per-channel pending flits and downstream credits, drives the arbiter's request vector, and consumes its one-hot grant plus success.
- Outputs a registered transfer strobe and winner index to the crossbar and buffer read logic.
- Checks the arbiter protocol and flags violations.

---
 rtl/tree_arb_requester.sv | 92 +++++++++
 tb/tb_tree_arb_requester.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tree_arb_requester.sv
// Requester side of the switch-allocation tree arbiter: per-channel pending/credit tracking, request generation,
// grant consumption and protocol checking; transfer strobe is registered (1 cycle after fire); upstream stalls on pending_full.
module tree_arb_requester #(
    parameter int size       = 20,
    parameter int groupsize  = 4,
    parameter int cnt_w      = 3,
    parameter int credit_max = 4,
    parameter int credit_w   = 3,
    localparam int idx_w     = $clog2(size),
    localparam int n_grp     = size / groupsize
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [size-1:0]  enq,
    input  logic [size-1:0]  credit_in,
    input  logic [size-1:0]  grant,
    input  logic             success,
    output logic [size-1:0]  request,
    output logic [n_grp-1:0] group_req,
    output logic [size-1:0]  pending_full,
    output logic             xfer_valid,
    output logic [idx_w-1:0] xfer_idx,
    output logic             error
);

    localparam logic [cnt_w-1:0]    pend_max = '1;
    localparam logic [credit_w-1:0] cred_rst = credit_w'(credit_max);

    logic [size-1:0][cnt_w-1:0]    pending_q, pending_d;
    logic [size-1:0][credit_w-1:0] credit_q, credit_d;
    logic [size-1:0]               fire;
    logic [size-1:0]               pend_ovf;
    logic [size-1:0]               cred_ovf;
    logic                          grant_multi;
    logic                          grant_onehot;
    logic                          grant_unreq;
    logic                          proto_err;
    logic [idx_w-1:0]              fire_idx;

    // Grant checks look only at grant and the registered request, so no loop exists through the arbiter.
    assign grant_multi  = (grant & (grant - size'(1))) != '0;
    assign grant_onehot = (grant != '0) && !grant_multi;
    assign grant_unreq  = |(grant & ~request);
    assign proto_err    = success && (grant_multi || grant_unreq);
    assign fire         = grant & request & {size{success && grant_onehot}};

    for (genvar i = 0; i < size; i++) begin : g_chan
        assign request[i]      = (pending_q[i] != '0) && (credit_q[i] != '0);
        assign pending_full[i] = (pending_q[i] == pend_max);
        assign pend_ovf[i]     = enq[i] && !fire[i] && (pending_q[i] == pend_max);
        assign cred_ovf[i]     = credit_in[i] && !fire[i] && (credit_q[i] == cred_rst);
        assign pending_d[i]    = pend_ovf[i] ? pending_q[i]
                               : pending_q[i] + cnt_w'(enq[i]) - cnt_w'(fire[i]);
        assign credit_d[i]     = cred_ovf[i] ? credit_q[i]
                               : credit_q[i] + credit_w'(credit_in[i]) - credit_w'(fire[i]);
    end

    for (genvar g = 0; g < n_grp; g++) begin : g_grp
        assign group_req[g] = |request[g*groupsize +: groupsize];
    end

    // fire is at most one-hot, so OR-ing indices is a valid binary encoder.
    always_comb begin
        fire_idx = '0;
        for (int i = 0; i < size; i++) begin
            if (fire[i]) begin
                fire_idx = fire_idx | idx_w'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            credit_q   <= {size{cred_rst}};
            xfer_valid <= 1'b0;
            xfer_idx   <= '0;
            error      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            credit_q   <= credit_d;
            xfer_valid <= |fire;
            if (|fire) begin
                xfer_idx <= fire_idx;
            end
            if (proto_err || (|pend_ovf) || (|cred_ovf)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tree_arb_requester.sv
// Directed bench for tree_arb_requester: inputs driven and outputs sampled 1ns after the rising edge.
module tb_tree_arb_requester;

    localparam int size  = 20;
    localparam int n_grp = 5;

    logic            clk;
    logic            rst_n;
    logic [19:0]     enq;
    logic [19:0]     credit_in;
    logic [19:0]     grant;
    logic            success;
    logic [19:0]     request;
    logic [4:0]      group_req;
    logic [19:0]     pending_full;
    logic            xfer_valid;
    logic [4:0]      xfer_idx;
    logic            error;

    int n_checks;
    int n_fail;

    tree_arb_requester #(
        .size(size), .groupsize(4), .cnt_w(3), .credit_max(4), .credit_w(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enq(enq), .credit_in(credit_in), .grant(grant),
        .success(success), .request(request), .group_req(group_req),
        .pending_full(pending_full), .xfer_valid(xfer_valid), .xfer_idx(xfer_idx),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        enq = '0; credit_in = '0; grant = '0; success = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (request !== 20'h0) begin n_fail++; $display("FAIL reset_request got %h want 00000", request); end
        n_checks++; if (group_req !== 5'h0) begin n_fail++; $display("FAIL reset_group_req got %b want 00000", group_req); end
        n_checks++; if (pending_full !== 20'h0) begin n_fail++; $display("FAIL reset_pending_full got %h want 00000", pending_full); end
        n_checks++; if (xfer_valid !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_valid got %b want 0", xfer_valid); end
        n_checks++; if (xfer_idx !== 5'd0) begin n_fail++; $display("FAIL reset_xfer_idx got %0d want 0", xfer_idx); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        n_checks++; if (dut.credit_q !== {20{3'd4}}) begin n_fail++; $display("FAIL reset_credit got %h want all 4", dut.credit_q); end
    endtask

    task automatic test_single_grant;
        enq = 20'h00020;
        tick();
        enq = '0;
        n_checks++; if (request !== 20'h00020) begin n_fail++; $display("FAIL single_request got %h want 00020", request); end
        n_checks++; if (group_req !== 5'b00010) begin n_fail++; $display("FAIL single_group_req got %b want 00010", group_req); end
        grant = 20'h00020; success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (request !== 20'h0) begin n_fail++; $display("FAIL single_request_drop got %h want 00000", request); end
        n_checks++; if (dut.pending_q[5] !== 3'd0) begin n_fail++; $display("FAIL single_pending got %0d want 0", dut.pending_q[5]); end
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd5) begin n_fail++; $display("FAIL single_xfer got v=%b idx=%0d want v=1 idx=5", xfer_valid, xfer_idx); end
        tick();
        n_checks++; if (xfer_valid !== 1'b0 || xfer_idx !== 5'd5) begin n_fail++; $display("FAIL single_xfer_hold got v=%b idx=%0d want v=0 idx=5", xfer_valid, xfer_idx); end
        n_checks++; if (dut.credit_q[5] !== 3'd3 || error !== 1'b0) begin n_fail++; $display("FAIL single_credit got c=%0d err=%b want c=3 err=0", dut.credit_q[5], error); end
    endtask

    task automatic test_no_success;
        enq = 20'h00008;
        tick();
        tick();
        enq = '0;
        grant = 20'h00008; success = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (request[3] !== 1'b1 || xfer_valid !== 1'b0) begin n_fail++; $display("FAIL nosucc_cycle%0d got req3=%b v=%b want req3=1 v=0", c, request[3], xfer_valid); end
        end
        n_checks++; if (dut.pending_q[3] !== 3'd2) begin n_fail++; $display("FAIL nosucc_pending got %0d want 2", dut.pending_q[3]); end
        success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (dut.pending_q[3] !== 3'd1) begin n_fail++; $display("FAIL nosucc_pending_after got %0d want 1", dut.pending_q[3]); end
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd3) begin n_fail++; $display("FAIL nosucc_xfer got v=%b idx=%0d want v=1 idx=3", xfer_valid, xfer_idx); end
        n_checks++; if (request !== 20'h00008) begin n_fail++; $display("FAIL nosucc_request got %h want 00008", request); end
        grant = 20'h00008; success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (request !== 20'h0 || dut.credit_q[3] !== 3'd2) begin n_fail++; $display("FAIL nosucc_drain got req=%h c=%0d want req=00000 c=2", request, dut.credit_q[3]); end
    endtask

    task automatic test_credit_stall;
        enq = 20'h00001;
        repeat (5) tick();
        enq = '0;
        grant = 20'h00001; success = 1'b1;
        repeat (4) tick();
        clear_inputs();
        n_checks++; if (request[0] !== 1'b0) begin n_fail++; $display("FAIL stall_request got %b want 0", request[0]); end
        n_checks++; if (dut.credit_q[0] !== 3'd0 || dut.pending_q[0] !== 3'd1) begin n_fail++; $display("FAIL stall_counts got c=%0d p=%0d want c=0 p=1", dut.credit_q[0], dut.pending_q[0]); end
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd0) begin n_fail++; $display("FAIL stall_xfer got v=%b idx=%0d want v=1 idx=0", xfer_valid, xfer_idx); end
        credit_in = 20'h00001;
        tick();
        credit_in = '0;
        n_checks++; if (request[0] !== 1'b1 || dut.credit_q[0] !== 3'd1) begin n_fail++; $display("FAIL stall_release got req=%b c=%0d want req=1 c=1", request[0], dut.credit_q[0]); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL stall_error got %b want 0", error); end
    endtask

    task automatic test_saturate;
        enq = 20'h00080;
        repeat (7) tick();
        n_checks++; if (pending_full !== 20'h00080 || error !== 1'b0) begin n_fail++; $display("FAIL sat_full got pf=%h err=%b want pf=00080 err=0", pending_full, error); end
        tick();
        enq = '0;
        n_checks++; if (dut.pending_q[7] !== 3'd7 || error !== 1'b1) begin n_fail++; $display("FAIL sat_overflow got p=%0d err=%b want p=7 err=1", dut.pending_q[7], error); end
        enq = 20'h00080; grant = 20'h00080; success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (dut.pending_q[7] !== 3'd7 || dut.credit_q[7] !== 3'd3) begin n_fail++; $display("FAIL sat_enq_fire got p=%0d c=%0d want p=7 c=3", dut.pending_q[7], dut.credit_q[7]); end
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd7) begin n_fail++; $display("FAIL sat_xfer got v=%b idx=%0d want v=1 idx=7", xfer_valid, xfer_idx); end
        repeat (3) tick();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got %b want 1", error); end
    endtask

    task automatic test_credit_overflow;
        do_reset();
        credit_in = 20'h00400;
        tick();
        credit_in = '0;
        n_checks++; if (error !== 1'b1 || dut.credit_q[10] !== 3'd4) begin n_fail++; $display("FAIL credovf got err=%b c=%0d want err=1 c=4", error, dut.credit_q[10]); end
    endtask

    task automatic test_protocol;
        do_reset();
        success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (error !== 1'b0 || xfer_valid !== 1'b0) begin n_fail++; $display("FAIL proto_zero_grant got err=%b v=%b want err=0 v=0", error, xfer_valid); end
        enq = 20'h00202;
        tick();
        enq = '0;
        n_checks++; if (request !== 20'h00202) begin n_fail++; $display("FAIL proto_request got %h want 00202", request); end
        grant = 20'h00202; success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (error !== 1'b1 || xfer_valid !== 1'b0) begin n_fail++; $display("FAIL proto_multi got err=%b v=%b want err=1 v=0", error, xfer_valid); end
        n_checks++; if (dut.pending_q[1] !== 3'd1 || dut.pending_q[9] !== 3'd1) begin n_fail++; $display("FAIL proto_multi_pending got p1=%0d p9=%0d want 1 1", dut.pending_q[1], dut.pending_q[9]); end
        do_reset();
        grant = 20'h00010; success = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (error !== 1'b1 || xfer_valid !== 1'b0) begin n_fail++; $display("FAIL proto_unreq got err=%b v=%b want err=1 v=0", error, xfer_valid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        enq = 20'hC0C00;
        tick();
        enq = '0;
        grant = 20'h00400; success = 1'b1;
        tick();
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd10) begin n_fail++; $display("FAIL b2b_first got v=%b idx=%0d want v=1 idx=10", xfer_valid, xfer_idx); end
        grant = 20'h00800;
        tick();
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd11) begin n_fail++; $display("FAIL b2b_second got v=%b idx=%0d want v=1 idx=11", xfer_valid, xfer_idx); end
        grant = 20'h80000;
        tick();
        clear_inputs();
        n_checks++; if (xfer_valid !== 1'b1 || xfer_idx !== 5'd19) begin n_fail++; $display("FAIL b2b_third got v=%b idx=%0d want v=1 idx=19", xfer_valid, xfer_idx); end
        n_checks++; if (request !== 20'h40000 || group_req !== 5'b10000) begin n_fail++; $display("FAIL b2b_request got req=%h grp=%b want req=40000 grp=10000", request, group_req); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        enq = 20'h00004; credit_in = 20'h00040;
        tick();
        clear_inputs();
        n_checks++; if (error !== 1'b1 || request !== 20'h00004) begin n_fail++; $display("FAIL mid_pre got err=%b req=%h want err=1 req=00004", error, request); end
        grant = 20'h00004; success = 1'b1; rst_n = 1'b0;
        tick();
        clear_inputs();
        rst_n = 1'b1;
        n_checks++; if (xfer_valid !== 1'b0 || request !== 20'h0) begin n_fail++; $display("FAIL mid_xfer got v=%b req=%h want v=0 req=00000", xfer_valid, request); end
        n_checks++; if (dut.credit_q !== {20{3'd4}} || error !== 1'b0) begin n_fail++; $display("FAIL mid_state got c=%h err=%b want all 4 err=0", dut.credit_q, error); end
        tick();
        n_checks++; if (xfer_valid !== 1'b0) begin n_fail++; $display("FAIL mid_late_xfer got %b want 0", xfer_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_grant();
        test_no_success();
        test_credit_stall();
        test_saturate();
        test_credit_overflow();
        test_protocol();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
